// File: rtl/sobel_window_sched_if.sv
// Bundle of the pixel-in stream, the Sobel-core handshake and the result-out
// stream for sobel_window_sched. The master modport is the scheduler side.
`timescale 1ns/1ps
interface sobel_window_sched_if #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic          pix_valid_i;
  logic [7:0]    pix_i;
  logic          pix_ready_o;
  logic          core_en_o;
  logic [71:0]   core_win_o;
  logic [8:0]    core_data_i;
  logic          core_done_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [7:0]    res_data_o;
  logic [XW-1:0] res_x_o;
  logic [YW-1:0] res_y_o;
  logic          frame_done_o;
  logic          err_o;

  modport master (
    input  pix_valid_i, pix_i, core_data_i, core_done_i, res_ready_i,
    output pix_ready_o, core_en_o, core_win_o, res_valid_o, res_data_o,
           res_x_o, res_y_o, frame_done_o, err_o
  );

  modport slave (
    output pix_valid_i, pix_i, core_data_i, core_done_i, res_ready_i,
    input  pix_ready_o, core_en_o, core_win_o, res_valid_o, res_data_o,
           res_x_o, res_y_o, frame_done_o, err_o
  );
endinterface

// File: rtl/sobel_window_sched.sv
// Raster-to-3x3-window sequencer for the Sobel core. Keeps two line buffers
// and a 3x3 window, runs one core job per interior pixel and returns the
// clipped 8-bit result on a valid/ready stream.
// Optional core watchdog: define SOBEL_SCHED_TIMEOUT_EN to enable it.
`timescale 1ns/1ps
module sobel_window_sched #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic clk_i_s,
  input  logic rst_i_s,
  sobel_window_sched_if.master bus
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  typedef enum logic [2:0] {S_FILL, S_ISSUE, S_WAIT, S_GAP, S_OUT} state_t;

  state_t        state_q, state_d;
  logic          active_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [7:0]    lb0_q [IMG_W];   // line y-1
  logic [7:0]    lb1_q [IMG_W];   // line y-2
  logic [71:0]   win_q;
  logic [7:0]    res_data_q;
  logic [XW-1:0] res_x_q;
  logic [YW-1:0] res_y_q;

  logic pix_acc, x_last, y_last, win_done, core_hit, timeout_hit, res_hs;

  // Core results are 9 bits; anything above 255 clips to full scale.
  function automatic logic [7:0] sat_u8(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

  // Shift the window one column left and insert a new right column
  // (top = line y-2, mid = line y-1, bot = current line).
  function automatic logic [71:0] shift_in(input logic [71:0] w,
                                           input logic [7:0] top,
                                           input logic [7:0] mid,
                                           input logic [7:0] bot);
    logic [71:0] r;
    r = w;
    for (int row = 0; row < 3; row++) begin
      r[8*(3*row)   +: 8] = w[8*(3*row+1) +: 8];
      r[8*(3*row+1) +: 8] = w[8*(3*row+2) +: 8];
    end
    r[8*2 +: 8] = top;
    r[8*5 +: 8] = mid;
    r[8*8 +: 8] = bot;
    return r;
  endfunction

  assign pix_acc  = bus.pix_valid_i && bus.pix_ready_o;
  assign x_last   = (x_q == XW'(IMG_W-1));
  assign y_last   = (y_q == YW'(IMG_H-1));
  assign win_done = pix_acc && (x_q >= XW'(2)) && (y_q >= YW'(2));
  assign core_hit = (state_q == S_WAIT) && bus.core_done_i;
  assign res_hs   = (state_q == S_OUT) && bus.res_ready_i;

`ifdef SOBEL_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0] wait_cnt_q;
  logic          err_q;

  assign timeout_hit = (state_q == S_WAIT) && !bus.core_done_i &&
                       (wait_cnt_q == CW'(TIMEOUT-1));
  assign bus.err_o   = err_q;

  // Watchdog: count WAIT cycles, flag a core that never answers (sticky).
  always_ff @(posedge clk_i_s) begin
    if (rst_i_s) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q != S_WAIT) wait_cnt_q <= '0;
      else                   wait_cnt_q <= wait_cnt_q + CW'(1);
      if (timeout_hit)       err_q      <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  // Constant 0: without the watchdog TIMEOUT has no effect on behaviour.
  assign bus.err_o   = (TIMEOUT < 0);
`endif

  // Input acceptance is held off for one cycle after reset releases.
  always_ff @(posedge clk_i_s) begin
    if (rst_i_s) active_q <= 1'b0;
    else         active_q <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk_i_s) begin
    if (rst_i_s) state_q <= S_FILL;
    else         state_q <= state_d;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d          = state_q;
    bus.pix_ready_o  = 1'b0;
    bus.core_en_o    = 1'b0;
    bus.res_valid_o  = 1'b0;
    bus.frame_done_o = 1'b0;
    case (state_q)
      S_FILL: begin
        bus.pix_ready_o = active_q;
        if (win_done) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        bus.core_en_o = 1'b1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        bus.core_en_o = 1'b1;
        if (core_hit || timeout_hit) state_d = S_GAP;
      end
      S_GAP: state_d = S_OUT;
      S_OUT: begin
        bus.res_valid_o  = 1'b1;
        bus.frame_done_o = res_hs && (res_x_q == XW'(IMG_W-2)) &&
                           (res_y_q == YW'(IMG_H-2));
        if (res_hs) state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
  end

  // Raster position of the next incoming pixel.
  always_ff @(posedge clk_i_s) begin
    if (rst_i_s) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pix_acc) begin
      if (x_last) begin
        x_q <= '0;
        y_q <= y_last ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // Line buffers: age column x by one line on every accepted pixel.
  always_ff @(posedge clk_i_s) begin
    if (pix_acc) begin
      lb1_q[x_q] <= lb0_q[x_q];
      lb0_q[x_q] <= bus.pix_i;
    end
  end

  // Window register: only moves in FILL, so it is frozen while the core runs.
  always_ff @(posedge clk_i_s) begin
    if (rst_i_s)      win_q <= '0;
    else if (pix_acc) win_q <= shift_in(win_q, lb1_q[x_q], lb0_q[x_q], bus.pix_i);
  end

  // Result register: centre coordinates at issue, clipped value at done.
  always_ff @(posedge clk_i_s) begin
    if (rst_i_s) begin
      res_data_q <= '0;
      res_x_q    <= '0;
      res_y_q    <= '0;
    end else begin
      if (win_done) begin
        res_x_q <= x_q - XW'(1);
        res_y_q <= y_q - YW'(1);
      end
      if (core_hit)         res_data_q <= sat_u8(bus.core_data_i);
      else if (timeout_hit) res_data_q <= 8'd0;
    end
  end

  assign bus.core_win_o = win_q;
  assign bus.res_data_o = res_data_q;
  assign bus.res_x_o    = res_x_q;
  assign bus.res_y_o    = res_y_q;
endmodule

// File: tb/tb_sobel_window_sched.sv
// Bench for sobel_window_sched on a 4x4 image with a behavioural Sobel-core
// stand-in and an image-level model of the expected result stream.
`timescale 1ns/1ps
module tb_sobel_window_sched;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_window_sched_if #(.IMG_W(W), .IMG_H(H)) bus();
  sobel_window_sched #(.IMG_W(W), .IMG_H(H), .TIMEOUT(TO)) dut (
    .clk_i_s (clk),
    .rst_i_s (rst),
    .bus     (bus)
  );

  typedef struct {
    int          cx;
    int          cy;
    logic [71:0] win;
    logic [7:0]  data;
    bit          last;
  } exp_t;

  exp_t       q[$];
  int         rx_d[$];
  int         rx_x[$];
  int         rx_y[$];
  int         fd_cnt;
  int         n_chk = 0;
  int         n_err = 0;
  bit         chk_en = 0;
  int         core_mode = 0;   // 0: constant core_val, 1: window byte 4, 2: never answers
  int         core_val = 100;
  int         core_lat = 20;
  logic [7:0] img [H][W];
  int         tb_x = 0;
  int         tb_y = 0;
  int         acc_cnt = 0;
  int         ex_x[4] = '{1, 2, 1, 2};
  int         ex_y[4] = '{1, 1, 2, 2};
  int         ex_c[4] = '{11, 12, 21, 22};

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rx_at(input int kind, input int i);
    if (kind == 0) return (i < rx_d.size()) ? rx_d[i] : -1;
    if (kind == 1) return (i < rx_x.size()) ? rx_x[i] : -1;
    return (i < rx_y.size()) ? rx_y[i] : -1;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pix_ready"},  bus.pix_ready_o,  0);
    chk({tag, "_core_en"},    bus.core_en_o,    0);
    chk({tag, "_core_win"},   bus.core_win_o,   0);
    chk({tag, "_res_valid"},  bus.res_valid_o,  0);
    chk({tag, "_res_data"},   bus.res_data_o,   0);
    chk({tag, "_res_x"},      bus.res_x_o,      0);
    chk({tag, "_res_y"},      bus.res_y_o,      0);
    chk({tag, "_frame_done"}, bus.frame_done_o, 0);
    chk({tag, "_err"},        bus.err_o,        0);
  endtask

  task automatic new_frame();
    tb_x = 0;
    tb_y = 0;
    fd_cnt = 0;
    rx_d.delete();
    rx_x.delete();
    rx_y.delete();
  endtask

  // Present one pixel, wait for acceptance, and record what the model expects.
  task automatic send_pix(input logic [7:0] v);
    int   w;
    exp_t e;
    @(negedge clk);
    bus.pix_valid_i = 1'b1;
    bus.pix_i       = v;
    w = 0;
    while (!bus.pix_ready_o && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!bus.pix_ready_o) begin
      n_chk++;
      n_err++;
      $display("FAIL pix_accept_timeout: got ready=0 for %0d cycles, want ready=1", w);
      bus.pix_valid_i = 1'b0;
      return;
    end
    img[tb_y][tb_x] = v;
    if (tb_x >= 2 && tb_y >= 2) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.win[8*(3*r+c) +: 8] = img[tb_y-2+r][tb_x-2+c];
      e.cx   = tb_x - 1;
      e.cy   = tb_y - 1;
      e.last = (e.cx == W-2) && (e.cy == H-2);
      case (core_mode)
        0:       e.data = (core_val > 255) ? 8'd255 : 8'(core_val);
        1:       e.data = img[tb_y-1][tb_x-1];
        default: e.data = 8'd0;
      endcase
      q.push_back(e);
    end
    acc_cnt++;
    if (tb_x == W-1) begin
      tb_x = 0;
      tb_y = (tb_y == H-1) ? 0 : tb_y + 1;
    end else begin
      tb_x++;
    end
    @(posedge clk);
    #1 bus.pix_valid_i = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain_timeout: got %0d results pending, want 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input int pat);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        send_pix(pat == 0 ? 8'(10*y + x) : 8'($urandom_range(0, 255)));
    drain();
  endtask

  task automatic check_const_frame(input string tag, input int val);
    chk({tag, "_count"}, rx_d.size(), 4);
    chk({tag, "_fd_count"}, fd_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_data"}, rx_at(0, i), val);
      chk({tag, "_x"},    rx_at(1, i), ex_x[i]);
      chk({tag, "_y"},    rx_at(2, i), ex_y[i]);
    end
  endtask

  // Sobel-core stand-in: answer core_core_lat cycles after enable.
  initial begin
    int n;
    bit ab;
    bus.core_done_i = 1'b0;
    bus.core_data_i = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.core_en_o && core_mode != 2) begin
        n  = 0;
        ab = 0;
        while (n < core_lat && !ab) begin
          @(negedge clk);
          n++;
          if (rst) ab = 1;
        end
        if (!ab) begin
          bus.core_data_i = (core_mode == 1) ? {1'b0, bus.core_win_o[39:32]} : 9'(core_val);
          bus.core_done_i = 1'b1;
          @(negedge clk);
          bus.core_done_i = 1'b0;
          chk("en_drop_after_done",    bus.core_en_o,   0);
          chk("valid_low_in_gap",      bus.res_valid_o, 0);
          @(negedge clk);
          chk("valid_two_after_done",  bus.res_valid_o, 1);
        end
      end
    end
  end

  // Per-cycle comparison of the DUT against the model queue.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (bus.core_en_o) begin
          if (q.size() == 0) chk("core_win_unexpected", bus.core_en_o, 0);
          else               chk("core_win", bus.core_win_o, q[0].win);
        end
        if (bus.res_valid_o && bus.res_ready_i) begin
          if (q.size() == 0) begin
            chk("res_unexpected", bus.res_valid_o, 0);
          end else begin
            chk("res_data",   bus.res_data_o,   q[0].data);
            chk("res_x",      bus.res_x_o,      q[0].cx);
            chk("res_y",      bus.res_y_o,      q[0].cy);
            chk("frame_done", bus.frame_done_o, q[0].last);
            rx_d.push_back(int'(bus.res_data_o));
            rx_x.push_back(int'(bus.res_x_o));
            rx_y.push_back(int'(bus.res_y_o));
            if (bus.frame_done_o) fd_cnt++;
            void'(q.pop_front());
          end
        end else begin
          chk("frame_done_idle", bus.frame_done_o, 0);
        end
        chk("ready_vs_valid", bus.pix_ready_o & bus.res_valid_o, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, want finish");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    int w;
    int a0;
    int n;
    bus.pix_valid_i = 1'b0;
    bus.pix_i       = '0;
    bus.res_ready_i = 1'b1;

    // Reset state and ready rising one cycle after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("init");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_held_after_rst", bus.pix_ready_o, 0);
    @(negedge clk);
    chk("ready_up_after_rst", bus.pix_ready_o, 1);
    chk_en = 1;

    // Constant core result 100 at the four interior centres.
    core_mode = 0; core_val = 100;
    new_frame();
    send_frame(0);
    check_const_frame("f100", 100);

    // Core returns the centre byte: results are the centre pixels.
    core_mode = 1;
    new_frame();
    send_frame(0);
    chk("ctr_count", rx_d.size(), 4);
    for (int i = 0; i < 4; i++) chk("ctr_val", rx_at(0, i), ex_c[i]);

    // Clipping at both ends.
    core_mode = 0; core_val = 300;
    new_frame();
    send_frame(1);
    check_const_frame("f300", 255);
    core_val = 256;
    new_frame();
    send_frame(1);
    check_const_frame("f256", 255);
    core_val = 0;
    new_frame();
    send_frame(1);
    check_const_frame("f0", 0);

    // Back-pressure on the first result for 50 cycles.
    core_mode = 1;
    new_frame();
    bus.res_ready_i = 1'b0;
    fork
      send_frame(1);
      begin
        w = 0;
        while (!bus.res_valid_o && w < 500) begin
          @(negedge clk);
          w++;
        end
        chk("stall_valid_seen", bus.res_valid_o, 1);
        a0 = acc_cnt;
        repeat (50) begin
          @(negedge clk);
          chk("stall_valid",   bus.res_valid_o, 1);
          chk("stall_ready",   bus.pix_ready_o, 0);
          chk("stall_data",    bus.res_data_o,  q.size() ? q[0].data : 8'hXX);
          chk("stall_no_pix",  acc_cnt,         a0);
        end
        @(posedge clk);
        #1 bus.res_ready_i = 1'b1;
      end
    join
    chk("stall_count", rx_d.size(), 4);

    // Reset during the wait of the second window, then a clean frame.
    core_mode = 0; core_val = 100;
    new_frame();
    for (int i = 0; i < 12; i++) send_pix(8'(i * 7));
    repeat (3) @(negedge clk);
    chk("mid_wait_en", bus.core_en_o, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 0;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    new_frame();
    @(negedge clk);
    chk("ready_held_after_midrst", bus.pix_ready_o, 0);
    chk_en = 1;
    send_frame(1);
    check_const_frame("after_rst", 100);

`ifdef SOBEL_SCHED_TIMEOUT_EN
    // Silent core: forced zero result after TIMEOUT wait cycles, sticky error.
    core_mode = 2;
    new_frame();
    for (int i = 0; i < 11; i++) send_pix(8'(i + 1));
    n = 0;
    w = 0;
    while (w < 200) begin
      @(negedge clk);
      if (bus.core_en_o) n++;
      else if (n > 0) break;
      w++;
    end
    chk("to_en_cycles", n, TO + 1);
    chk("to_err_set", bus.err_o, 1);
    for (int i = 11; i < 16; i++) send_pix(8'(i + 1));
    drain();
    chk("to_count", rx_d.size(), 4);
    chk("to_data0", rx_at(0, 0), 0);
    chk("to_err_sticky", bus.err_o, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 0;
    @(posedge clk);
    @(negedge clk);
    chk("to_err_cleared", bus.err_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
`else
    chk("err_tied_low", bus.err_o, 0);
    n = 0;
    a0 = 0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
